fifo_native2stream_prefetch: RTL and testbench
==============================================

FIFO_NATIVE2STREAM_PREFETCH -- requirements
Module: fifo_native2stream_prefetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, width of the FIFO read data and the stream data.
REQ-002 SHALL have parameter READ_LATENCY, default 1, range 1..4, cycles from rd_en high to valid dout.
REQ-003 SHALL have parameter BUF_DEPTH, default 4, power of two, at least READ_LATENCY+2, number of prefetch buffer entries.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port empty, input, 1, FIFO empty flag.
REQ-007 SHALL have port rd_en, output, 1, FIFO read strobe.
REQ-008 SHALL have port dout, input, DATA_WIDTH, FIFO read data, valid READ_LATENCY cycles after rd_en.
REQ-009 SHALL have port s_axis_tready, input, 1, stream sink ready.
REQ-010 SHALL have port s_axis_tvalid, output, 1, stream data valid.
REQ-011 SHALL have port s_axis_tdata, output, DATA_WIDTH, stream data.
REQ-012 SHALL have port buf_level, output, clog2(BUF_DEPTH+1), number of entries held in the prefetch buffer.

Function
REQ-013 SHALL hold a circular buffer of BUF_DEPTH entries, with write pointer, read pointer and occupancy count.
REQ-014 SHALL track in-flight reads with a READ_LATENCY-stage valid shift register; inflight = number of set stages.
REQ-015 SHALL drive rd_en = !empty && (occupancy + inflight < BUF_DEPTH), combinationally from registered state and empty only; s_axis_tready SHALL NOT reach rd_en.
REQ-016 SHALL write dout into the buffer at the rising edge ending cycle n+READ_LATENCY when rd_en was high in cycle n.
REQ-017 SHALL drive s_axis_tvalid = (occupancy != 0), and s_axis_tdata = entry at the read pointer.
REQ-018 SHALL pop one entry on each edge where s_axis_tvalid && s_axis_tready.
REQ-019 On a simultaneous write and pop, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-020 Pointers SHALL wrap modulo BUF_DEPTH with no lost or duplicated entry.
REQ-021 While s_axis_tvalid is high and s_axis_tready is low, s_axis_tdata SHALL be held stable.
REQ-022 Latency: with the buffer idle and empty falling in cycle 0, rd_en SHALL be high in cycle 0 and s_axis_tvalid high in cycle READ_LATENCY+1.
REQ-023 Throughput: with empty low and s_axis_tready high continuously, rd_en and s_axis_tvalid SHALL be high every cycle once steady state is reached.
REQ-024 The buffer SHALL never overflow: occupancy + inflight <= BUF_DEPTH at all times.
REQ-025 rd_en SHALL never be high while empty is high.
REQ-026 buf_level SHALL equal occupancy and SHALL exclude in-flight reads.
REQ-027 Stream order SHALL equal FIFO read order.

Reset
REQ-028 While rst_n is low, rd_en, s_axis_tvalid and buf_level SHALL be 0 and s_axis_tdata SHALL be all zeros.
REQ-029 While rst_n is low, pointers, occupancy and the in-flight shift register SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard buffered and in-flight data; no discarded word SHALL appear after reset release.
REQ-031 After rst_n rises, the first rd_en SHALL depend only on empty, per REQ-015.

Verification
REQ-032 SHALL cover: defaults, empty falls in cycle 0 with tready=1 -> rd_en=1 in cycle 0, tvalid=1 in cycle 2 with the first FIFO word.
REQ-033 SHALL cover: defaults, 16 words, tready=1 throughout -> 16 consecutive tvalid cycles, in order, no gaps after the first.
REQ-034 SHALL cover: tready=0 with words available -> buf_level saturates at 4, rd_en stays 0, tdata stable; tready then rises -> 4 words in order, then refill.
REQ-035 SHALL cover: READ_LATENCY=3, BUF_DEPTH=8, random empty and random tready for 10000 cycles -> scoreboard matches, no overflow, rd_en never high while empty is high.
REQ-036 SHALL cover: rst_n pulsed low with 3 entries buffered and 1 read in flight -> outputs are 0 immediately; after release, only new FIFO words appear.

Source files
------------

// File: rtl/fifo_native2stream_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_native2stream_prefetch
//  Description : Prefetching bridge from a native FIFO read port (rd_en/dout
//                with fixed read latency) to an AXI-Stream style source port.
//                Reads are issued only when the buffer is guaranteed to have
//                room for every in-flight word, so the sink's tready never
//                reaches rd_en combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_native2stream_prefetch #(
    parameter int DATA_WIDTH   = 256,
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           empty,
    output logic                           rd_en,
    input  logic [DATA_WIDTH-1:0]          dout,
    input  logic                           s_axis_tready,
    output logic                           s_axis_tvalid,
    output logic [DATA_WIDTH-1:0]          s_axis_tdata,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_level
);

    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);
    // One extra bit so occupancy + inflight can never wrap in the compare.
    localparam int c_SUM_W = c_CNT_W + 1;

    logic [DATA_WIDTH-1:0]   r_mem [BUF_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;
    logic [READ_LATENCY-1:0] r_sr;

    logic [c_SUM_W-1:0]      w_inflight;
    logic                    w_rd_en;
    logic                    w_wr;
    logic                    w_pop;

    // Count the outstanding reads: one set stage per word still in the FIFO pipeline.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + c_SUM_W'(r_sr[i]);
        end
    end

    // A read is issued only if the word is guaranteed a free slot on arrival.
    // rst_n gates the strobe so no read can be lost while state is held clear.
    assign w_rd_en = rst_n && !empty &&
                     ((c_SUM_W'(r_count) + w_inflight) < c_SUM_W'(BUF_DEPTH));

    // The last shift stage marks the cycle in which dout carries the read word.
    assign w_wr  = r_sr[READ_LATENCY-1];
    assign w_pop = (r_count != '0) && s_axis_tready;

    generate
        if (READ_LATENCY == 1) begin : g_sr_single
            // Single-stage read tracker.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= w_rd_en;
                end
            end
        end else begin : g_sr_multi
            // Multi-stage read tracker: shifts each read towards its dout cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[READ_LATENCY-2:0], w_rd_en};
                end
            end
        end
    endgenerate

    // Buffer storage; cleared on reset so no discarded word can resurface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= dout;
        end
    end

    // Pointers wrap naturally because BUF_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    // Occupancy: a simultaneous write and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_en         = w_rd_en;
    assign s_axis_tvalid = (r_count != '0);
    assign s_axis_tdata  = r_mem[r_rd_ptr];
    assign buf_level     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_native2stream_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_native2stream_prefetch
//  Description : Self-checking bench for fifo_native2stream_prefetch. Two
//                instances: defaults (latency 1, depth 4) for directed steps,
//                and latency 3 / depth 8 for a long randomised run. A FIFO
//                model supplies dout and pushes each issued word into an
//                expected-stream queue that is popped on every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_native2stream_prefetch;

    localparam logic [255:0] c_POISON = {64{4'hD}};
    localparam int           c_LAT [2] = '{1, 3};
    localparam int           c_DEPTH [2] = '{4, 8};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       empty;
    logic [1:0]       rd_en;
    logic [1:0]       tready;
    logic [1:0]       tvalid;
    logic [1:0][255:0] dout;
    logic [1:0][255:0] tdata;
    logic [2:0]       level0;
    logic [3:0]       level1;

    logic [255:0]     pipe [2][4];
    logic [3:0]       vp [2];
    logic [255:0]     exp_q [2][$];
    int               wcnt [2] = '{0, 0};
    int               total = 0;
    int               bad = 0;
    logic [255:0]     first;

    always #5 clk = ~clk;

    fifo_native2stream_prefetch dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .empty         (empty[0]),
        .rd_en         (rd_en[0]),
        .dout          (dout[0]),
        .s_axis_tready (tready[0]),
        .s_axis_tvalid (tvalid[0]),
        .s_axis_tdata  (tdata[0]),
        .buf_level     (level0)
    );

    fifo_native2stream_prefetch #(
        .DATA_WIDTH   (256),
        .READ_LATENCY (3),
        .BUF_DEPTH    (8)
    ) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .empty         (empty[1]),
        .rd_en         (rd_en[1]),
        .dout          (dout[1]),
        .s_axis_tready (tready[1]),
        .s_axis_tvalid (tvalid[1]),
        .s_axis_tdata  (tdata[1]),
        .buf_level     (level1)
    );

    assign dout[0] = pipe[0][c_LAT[0]-1];
    assign dout[1] = pipe[1][c_LAT[1]-1];

    function automatic logic [255:0] make_word(input int k, input int n);
        logic [31:0] w;
        w = 32'(n) ^ (32'(k) << 31) ^ 32'h1357_0000;
        return {{4{w}}, {4{~w}}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO model: each accepted read yields its word on dout after the read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                vp[k] <= '0;
                for (int j = 0; j < 4; j++) pipe[k][j] <= c_POISON;
                exp_q[k].delete();
            end else begin
                vp[k] <= {vp[k][2:0], rd_en[k]} & ((4'b1 << c_LAT[k]) - 4'b1);
                for (int j = 3; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
                if (rd_en[k]) begin
                    pipe[k][0] <= make_word(k, wcnt[k]);
                    exp_q[k].push_back(make_word(k, wcnt[k]));
                    wcnt[k]++;
                end else begin
                    pipe[k][0] <= c_POISON;
                end
            end
        end
    end

    // Scoreboard and invariant checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                int infl;
                int occ;
                int lv;
                infl = $countones(vp[k]);
                occ  = exp_q[k].size() - infl;
                lv   = (k == 0) ? int'(level0) : int'(level1);
                check("rd_en_while_empty", 256'(rd_en[k] & empty[k]), 256'(0));
                check("buf_level", 256'(lv), 256'(occ));
                check("no_overflow", 256'(exp_q[k].size() <= c_DEPTH[k]), 256'(1));
                check("tvalid", 256'(tvalid[k]), 256'(occ > 0));
                if (tvalid[k] && tready[k] && exp_q[k].size() > 0) begin
                    check("stream_data", tdata[k], exp_q[k][0]);
                    void'(exp_q[k].pop_front());
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        empty  = 2'b11;
        tready = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_rd_en", 256'(rd_en), 256'(0));
        check("rst_tvalid", 256'(tvalid), 256'(0));
        check("rst_level0", 256'(level0), 256'(0));
        check("rst_level1", 256'(level1), 256'(0));
        check("rst_tdata0", tdata[0], 256'(0));
        check("rst_tdata1", tdata[1], 256'(0));
        empty = 2'b00;
        #1;
        check("rst_rd_en_not_empty", 256'(rd_en), 256'(0));
        empty = 2'b11;
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_rd_en", 256'(rd_en), 256'(0));

        // Latency: empty falls in cycle 0
        tready[0] = 1'b1;
        empty[0]  = 1'b0;
        first     = make_word(0, wcnt[0]);
        #1;
        check("lat_rd_en_c0", 256'(rd_en[0]), 256'(1));
        check("lat_tvalid_c0", 256'(tvalid[0]), 256'(0));
        tick();
        empty[0] = 1'b1;
        #1;
        check("lat_tvalid_c1", 256'(tvalid[0]), 256'(0));
        tick();
        check("lat_tvalid_c2", 256'(tvalid[0]), 256'(1));
        check("lat_tdata_c2", tdata[0], first);
        tick();
        check("lat_tvalid_c3", 256'(tvalid[0]), 256'(0));

        // Throughput: 16 words back to back
        for (int i = 0; i < 20; i++) begin
            empty[0] = (i >= 16);
            #1;
            check("thr_rd_en", 256'(rd_en[0]), 256'(i < 16));
            check("thr_tvalid", 256'(tvalid[0]), 256'(i >= 2 && i < 18));
            tick();
        end

        // Backpressure: buffer saturates, data held stable
        tready[0] = 1'b0;
        empty[0]  = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_level", 256'(level0), 256'(4));
            check("bp_rd_en", 256'(rd_en[0]), 256'(0));
            check("bp_tvalid", 256'(tvalid[0]), 256'(1));
            check("bp_tdata_hold", tdata[0], exp_q[0][0]);
            tick();
        end
        empty[0]  = 1'b1;
        tready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("drain_tvalid", 256'(tvalid[0]), 256'(i < 4));
            check("drain_level", 256'(level0), 256'((i < 4) ? 4 - i : 0));
            tick();
        end
        empty[0] = 1'b0;
        #1;
        check("refill_rd_en", 256'(rd_en[0]), 256'(1));
        repeat (3) tick();
        empty[0] = 1'b1;
        repeat (6) tick();
        check("refill_done_tvalid", 256'(tvalid[0]), 256'(0));

        // Reset mid-operation: 3 buffered, 1 in flight
        tready[0] = 1'b0;
        empty[0]  = 1'b0;
        repeat (4) tick();
        check("pre_rst_level", 256'(level0), 256'(3));
        check("pre_rst_rd_en", 256'(rd_en[0]), 256'(0));
        rst_n    = 1'b0;
        empty[0] = 1'b1;
        #1;
        check("mid_rst_rd_en", 256'(rd_en[0]), 256'(0));
        check("mid_rst_tvalid", 256'(tvalid[0]), 256'(0));
        check("mid_rst_level", 256'(level0), 256'(0));
        check("mid_rst_tdata", tdata[0], 256'(0));
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_tvalid", 256'(tvalid[0]), 256'(0));
        check("rel_level", 256'(level0), 256'(0));
        tready[0] = 1'b1;
        empty[0]  = 1'b0;
        first     = make_word(0, wcnt[0]);
        #1;
        check("rel_rd_en", 256'(rd_en[0]), 256'(1));
        tick();
        empty[0] = 1'b1;
        tick();
        check("rel_new_tvalid", 256'(tvalid[0]), 256'(1));
        check("rel_new_tdata", tdata[0], first);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rel_no_stale", 256'(tvalid[0]), 256'(0));
        end

        // Randomised run on latency 3 / depth 8
        for (int n = 0; n < 10000; n++) begin
            empty[1]  = ($urandom_range(0, 3) == 0);
            tready[1] = ((n % 512) < 256) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 3) == 0);
            tick();
        end
        empty[1]  = 1'b1;
        tready[1] = 1'b1;
        repeat (20) tick();
        check("rand_drain_tvalid", 256'(tvalid[1]), 256'(0));
        check("rand_drain_queue", 256'(exp_q[1].size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
